// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer address sequencer.
// Latency: n/a (types and elaboration-time helper only).
// Backpressure: n/a.
package fc_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fc_state_t;

    // Width needed to count 0..n-1. The floor of 1 bit keeps a 1-deep
    // counter legal as a vector.
    function automatic int fc_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_nested_counter.sv
// Two wrapping counters (a: 0..A_N-1, b: 0..B_N-1); a_inner picks which one steps fastest.
// Latency: counts update on the clock edge that samples step; wrap flags are combinational.
// Backpressure: none; advances only on step, clr has priority over step.
//
// Ports: clk, rst_n (async, active low), clr (sync zero), step (advance once),
//        a_inner (1: a inner / b outer, 0: b inner / a outer),
//        a, b (current counts), a_last, b_last (count is at its final value).
module fc_nested_counter #(
    parameter int A_N = 4,
    parameter int B_N = 2,
    parameter int A_W = 2,
    parameter int B_W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           step,
    input  logic           a_inner,
    output logic [A_W-1:0] a,
    output logic [B_W-1:0] b,
    output logic           a_last,
    output logic           b_last
);

    assign a_last = (a == A_W'(A_N - 1));
    assign b_last = (b == B_W'(B_N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (clr) begin
            a <= '0;
            b <= '0;
        end else if (step) begin
            if (a_inner) begin
                if (a_last) begin
                    a <= '0;
                    b <= b_last ? '0 : b + B_W'(1);
                end else begin
                    a <= a + A_W'(1);
                end
            end else begin
                if (b_last) begin
                    b <= '0;
                    a <= a_last ? '0 : a + A_W'(1);
                end else begin
                    b <= b + B_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fc_addr_sequencer.sv
// Weight/bias address sequencer for one FC layer pass, forward (row) or backward (transposed).
// Latency: pointers/flags registered 1 cycle after the accepting valid_i beat; done_o 1 cycle after the final pointer.
// Backpressure: valid_i low stalls the walk (pointers hold, ptr_valid 0); toggling forward mid-pass aborts.
//
// Ports: clk, rst_n (async, active low), start_i (launch pulse), forward (traversal mode),
//        valid_i (operand beat), head_ptr / mid_ptr (weight addresses, both buffer halves),
//        bias_ptr, has_bias, ptr_valid, last_o (row end), done_o (pass end pulse), busy_o.
module fc_addr_sequencer
    import fc_pkg::*;
#(
    parameter int FAN_IN         = 16,
    parameter int FAN_OUT        = 16,
    parameter int LANES          = 4,
    parameter int ADDR           = 10,
    parameter int BIAS_ADDR      = 4,
    parameter int MID_PTR_OFFSET = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 forward,
    input  logic                 valid_i,
    output logic [ADDR-1:0]      head_ptr,
    output logic [ADDR-1:0]      mid_ptr,
    output logic [BIAS_ADDR-1:0] bias_ptr,
    output logic                 has_bias,
    output logic                 ptr_valid,
    output logic                 last_o,
    output logic                 done_o,
    output logic                 busy_o
);

    localparam int GROUPS = FAN_OUT / LANES;
    localparam int K_W    = fc_width(FAN_IN);
    localparam int G_W    = fc_width(GROUPS);

    // Backward walk steps by FAN_IN down a column; at the column end it
    // rewinds to the top of the next column, i.e. -(GROUPS-1)*FAN_IN + 1.
    localparam logic [ADDR-1:0] BWD_STEP = ADDR'(FAN_IN);
    localparam logic [ADDR-1:0] BWD_WRAP = ADDR'(1 - (GROUPS - 1) * FAN_IN);
    localparam logic [ADDR-1:0] MID_OFS  = ADDR'(MID_PTR_OFFSET);

    if (FAN_IN < 2) begin : g_bad_fan_in
        $error("fc_addr_sequencer: FAN_IN must be >= 2");
    end
    if (FAN_OUT % LANES != 0) begin : g_bad_lanes
        $error("fc_addr_sequencer: FAN_OUT must be a multiple of LANES");
    end
    if (ADDR < $clog2(GROUPS * FAN_IN + MID_PTR_OFFSET)) begin : g_bad_addr
        $error("fc_addr_sequencer: ADDR too narrow");
    end
    if (BIAS_ADDR < $clog2(GROUPS)) begin : g_bad_bias
        $error("fc_addr_sequencer: BIAS_ADDR too narrow");
    end

    fc_state_t       state_q, state_d;
    logic            fwd_q;
    logic            final_q;
    logic [ADDR-1:0] addr_q;
    logic [ADDR-1:0] addr_next;
    logic [K_W-1:0]  k;
    logic [G_W-1:0]  g;
    logic            k_last, g_last;
    logic            run, abort, beat, final_beat, cnt_clr;

    assign run        = (state_q == ST_RUN);
    assign abort      = run && (forward != fwd_q);
    // Once the final beat is taken, further valid_i in RUN is ignored.
    assign beat       = run && valid_i && !abort && !final_q;
    assign final_beat = beat && k_last && g_last;
    // Starting from IDLE consumes no beat even if valid_i is high.
    assign cnt_clr    = ((state_q == ST_IDLE) && start_i) || abort;

    fc_nested_counter #(
        .A_N (FAN_IN),
        .B_N (GROUPS),
        .A_W (K_W),
        .B_W (G_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .step    (beat),
        .a_inner (fwd_q),
        .a       (k),
        .b       (g),
        .a_last  (k_last),
        .b_last  (g_last)
    );

    // Running address g*FAN_IN + k, tracked with adds only.
    always_comb begin
        addr_next = addr_q + ADDR'(1);
        if (!fwd_q) begin
            addr_next = g_last ? (addr_q + BWD_WRAP) : (addr_q + BWD_STEP);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)        state_d = ST_IDLE;
                else if (final_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            fwd_q     <= 1'b0;
            final_q   <= 1'b0;
            addr_q    <= '0;
            head_ptr  <= '0;
            bias_ptr  <= '0;
            has_bias  <= 1'b0;
            ptr_valid <= 1'b0;
            last_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && start_i) begin
                fwd_q <= forward;
            end
            // Holds the one-cycle gap between the final pointer and done_o.
            final_q <= (state_d == ST_RUN) && (final_q || final_beat);
            if (cnt_clr) begin
                addr_q <= '0;
            end else if (beat) begin
                addr_q <= addr_next;
            end
            ptr_valid <= beat;
            has_bias  <= beat && fwd_q && (k == '0);
            last_o    <= beat && (fwd_q ? k_last : g_last);
            if (beat) begin
                head_ptr <= addr_q;
            end
            if (beat && fwd_q) begin
                bias_ptr <= BIAS_ADDR'(g);
            end
        end
    end

    assign mid_ptr = head_ptr + MID_OFS;
    assign done_o  = (state_q == ST_DONE);
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fc_addr_sequencer.sv
// Scoreboard bench for fc_addr_sequencer with FAN_IN=4, FAN_OUT=4, LANES=2, MID_PTR_OFFSET=16.
// Latency: expected beats queued by stimulus, popped by a negedge monitor on ptr_valid.
// Backpressure: stimulus gaps valid_i to exercise pointer hold.
module tb_fc_addr_sequencer;

    localparam int FAN_IN    = 4;
    localparam int FAN_OUT   = 4;
    localparam int LANES     = 2;
    localparam int ADDR      = 10;
    localparam int BIAS_ADDR = 4;
    localparam int MID       = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_i = 1'b0;
    logic                 forward = 1'b1;
    logic                 valid_i = 1'b0;
    logic [ADDR-1:0]      head_ptr;
    logic [ADDR-1:0]      mid_ptr;
    logic [BIAS_ADDR-1:0] bias_ptr;
    logic                 has_bias;
    logic                 ptr_valid;
    logic                 last_o;
    logic                 done_o;
    logic                 busy_o;

    fc_addr_sequencer #(
        .FAN_IN         (FAN_IN),
        .FAN_OUT        (FAN_OUT),
        .LANES          (LANES),
        .ADDR           (ADDR),
        .BIAS_ADDR      (BIAS_ADDR),
        .MID_PTR_OFFSET (MID)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .forward   (forward),
        .valid_i   (valid_i),
        .head_ptr  (head_ptr),
        .mid_ptr   (mid_ptr),
        .bias_ptr  (bias_ptr),
        .has_bias  (has_bias),
        .ptr_valid (ptr_valid),
        .last_o    (last_o),
        .done_o    (done_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int head;
        int bias;
        int hb;
        int last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Hand-derived traversal tables for the 2 groups x 4 inputs layer.
    int fwd_head [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int fwd_bias [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int fwd_hb   [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    int fwd_last [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int bwd_head [8] = '{0, 4, 1, 5, 2, 6, 3, 7};
    int bwd_last [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int last_head = 0;
    int prev_fin  = 0;
    int bias_hold = 0;
    int d0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every presented pointer.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_head = 0;
            prev_fin  = 0;
        end else begin
            if (done_o) begin
                done_cnt++;
                chk("done_after_final_ptr", 32'(prev_fin), 1);
            end
            if (ptr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ptr_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("head_ptr", 32'(head_ptr), mon_e.head);
                    chk("mid_ptr", 32'(mid_ptr), mon_e.head + MID);
                    chk("bias_ptr", 32'(bias_ptr), mon_e.bias);
                    chk("has_bias", 32'(has_bias), mon_e.hb);
                    chk("last_o", 32'(last_o), mon_e.last);
                end
                last_head = int'(head_ptr);
            end else begin
                chk("ptr_hold", 32'(head_ptr), last_head);
            end
            prev_fin = (ptr_valid && head_ptr == 7) ? 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic fwd);
        forward = fwd;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Issue n beats; gap inserts an idle cycle after each; start_on raises
    // start_i alongside that beat index (-1 for never).
    task automatic beats(input logic fwd, input int n, input logic gap, input int start_on);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (fwd) begin
                e.head = fwd_head[i];
                e.bias = fwd_bias[i];
                e.hb   = fwd_hb[i];
                e.last = fwd_last[i];
            end else begin
                e.head = bwd_head[i];
                e.bias = bias_hold;
                e.hb   = 0;
                e.last = bwd_last[i];
            end
            exp_q.push_back(e);
            valid_i = 1'b1;
            if (i == start_on) start_i = 1'b1;
            tick();
            start_i = 1'b0;
            valid_i = 1'b0;
            if (gap) tick();
        end
        if (fwd && n == 8) bias_hold = 1;
    endtask

    task automatic full_pass(input logic fwd, input logic gap, input int start_on, input string tag);
        d0 = done_cnt;
        start_pass(fwd);
        chk({tag, "_busy_in_run"}, 32'(busy_o), 1);
        beats(fwd, 8, gap, start_on);
        repeat (4) tick();
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_busy_after"}, 32'(busy_o), 0);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2;
        chk("rst_head_ptr", 32'(head_ptr), 0);
        chk("rst_mid_ptr", 32'(mid_ptr), MID);
        chk("rst_bias_ptr", 32'(bias_ptr), 0);
        chk("rst_has_bias", 32'(has_bias), 0);
        chk("rst_ptr_valid", 32'(ptr_valid), 0);
        chk("rst_last_o", 32'(last_o), 0);
        chk("rst_done_o", 32'(done_o), 0);
        chk("rst_busy_o", 32'(busy_o), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Forward, continuous valid.
        full_pass(1'b1, 1'b0, -1, "fwd");
        // Backward, continuous valid; bias_ptr holds at last forward group.
        full_pass(1'b0, 1'b0, -1, "bwd");
        // Forward with valid_i low every other cycle.
        full_pass(1'b1, 1'b1, -1, "fwd_gap");

        // Forward toggled after the 3rd beat aborts the pass.
        d0 = done_cnt;
        start_pass(1'b1);
        beats(1'b1, 3, 1'b0, -1);
        forward = 1'b0;
        tick();
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_ptr_valid", 32'(ptr_valid), 0);
        forward = 1'b1;
        repeat (4) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue", exp_q.size(), 0);
        full_pass(1'b1, 1'b0, -1, "restart");

        // start_i during RUN is ignored.
        full_pass(1'b1, 1'b0, 2, "start_in_run");

        // Reset mid-pass.
        d0 = done_cnt;
        start_pass(1'b1);
        beats(1'b1, 4, 1'b0, -1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_head_ptr", 32'(head_ptr), 0);
        chk("midrst_mid_ptr", 32'(mid_ptr), MID);
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_ptr_valid", 32'(ptr_valid), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_busy_after", 32'(busy_o), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_addr_sequencer.md
FC_ADDR_SEQUENCER -- requirements
Module: fc_addr_sequencer

Interface
REQ-001 The module SHALL have parameter FAN_IN, default 16: input activations per neuron; must be >= 2.
REQ-002 The module SHALL have parameter FAN_OUT, default 16: neurons in the layer.
REQ-003 The module SHALL have parameter LANES, default 4: neurons processed in parallel; FAN_OUT % LANES == 0 (elaboration error otherwise); GROUPS = FAN_OUT/LANES.
REQ-004 The module SHALL have parameter ADDR, default 10: weight pointer width; ADDR >= clog2(GROUPS*FAN_IN + MID_PTR_OFFSET).
REQ-005 The module SHALL have parameter BIAS_ADDR, default 4: bias pointer width; BIAS_ADDR >= clog2(GROUPS).
REQ-006 The module SHALL have parameter MID_PTR_OFFSET, default 512: base offset of the second weight buffer half.
REQ-007 The module SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-008 The module SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 The module SHALL have port start_i, input, 1: single-cycle pulse that launches one pass.
REQ-010 The module SHALL have port forward, input, 1: 1 = forward traversal, 0 = backward (transposed).
REQ-011 The module SHALL have port valid_i, input, 1: one operand beat consumed this cycle.
REQ-012 The module SHALL have port head_ptr, output, ADDR: weight address, lower half.
REQ-013 The module SHALL have port mid_ptr, output, ADDR: head_ptr + MID_PTR_OFFSET.
REQ-014 The module SHALL have port bias_ptr, output, BIAS_ADDR: current neuron group.
REQ-015 The module SHALL have port has_bias, output, 1: bias add on this beat (forward only).
REQ-016 The module SHALL have port ptr_valid, output, 1: pointers are valid this cycle.
REQ-017 The module SHALL have port last_o, output, 1: last beat of an accumulation row.
REQ-018 The module SHALL have port done_o, output, 1: one-cycle pulse at pass completion.
REQ-019 The module SHALL have port busy_o, output, 1: high when the FSM is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DONE; IDLE->RUN on start_i, RUN->DONE after the final beat, and DONE->IDLE unconditionally after 1 cycle.
REQ-021 In RUN, the mode SHALL be latched from forward at start; the traversal counters are k (0..FAN_IN-1) and g (0..GROUPS-1).
REQ-022 In forward mode, each valid_i beat SHALL issue head_ptr = g*FAN_IN + k; k is the inner counter and wraps to 0 with g+1.
REQ-023 In backward mode, each valid_i beat SHALL issue head_ptr = g*FAN_IN + k; g is the inner counter and wraps to 0 with k+1, so the stride is FAN_IN, generated by adding, not multiplying.
REQ-024 Outputs SHALL be registered: pointers, ptr_valid, has_bias and last_o appear 1 cycle after the accepting valid_i beat.
REQ-025 When valid_i is low in RUN, pointers SHALL hold and ptr_valid SHALL be 0.
REQ-026 mid_ptr SHALL always equal head_ptr + MID_PTR_OFFSET, truncated to ADDR bits.
REQ-027 In forward mode, has_bias SHALL be 1 on the beat with k==0 and bias_ptr = g; in backward mode has_bias SHALL be 0 and bias_ptr holds.
REQ-028 last_o SHALL be 1 on the beat with k==FAN_IN-1 in forward mode, and on the beat with g==GROUPS-1 in backward mode.
REQ-029 The final beat SHALL be (g,k) = (GROUPS-1, FAN_IN-1) in either mode; done_o pulses in the cycle after that beat's outputs.
REQ-030 If forward toggles during RUN, the FSM SHALL abort to IDLE next cycle: counters zeroed, ptr_valid 0, no done_o.
REQ-031 start_i outside IDLE SHALL be ignored; valid_i in IDLE or DONE SHALL be ignored.
REQ-032 If start_i and valid_i arrive in the same cycle, the FSM enters RUN only; that valid_i is not consumed.

Reset
REQ-033 While rst_n is low, the block SHALL force IDLE, k=g=0, head_ptr=0, mid_ptr=MID_PTR_OFFSET, bias_ptr=0, and has_bias, ptr_valid, last_o, done_o and busy_o all 0.
REQ-034 Reset assertion mid-pass SHALL abort immediately; no done_o is produced after release.

Structure
REQ-035 The FSM state enum and a clog2-based width helper SHALL live in the shared package fc_pkg.
REQ-036 A single sub-module, fc_nested_counter (two wrapping counters with inner/outer select), SHALL implement the k/g traversal.

Verification
REQ-037 The bench SHALL cover: FAN_IN=4, FAN_OUT=4, LANES=2, forward, continuous valid -> head_ptr 0..7, has_bias at ptr 0 and 4 with bias_ptr 0 and 1, last_o at 3 and 7, done_o 1 cycle after ptr 7.
REQ-038 The bench SHALL cover: same parameters, backward -> head_ptr 0,4,1,5,2,6,3,7; last_o at 4,5,6,7; has_bias never 1.
REQ-039 The bench SHALL cover: forward with valid_i low every other cycle -> same 8-pointer sequence, ptr_valid alternating, pointers held while low.
REQ-040 The bench SHALL cover: forward toggled after the 3rd beat -> busy_o 0 next cycle, no done_o, a following start_i restarts at ptr 0.
REQ-041 The bench SHALL cover: rst_n pulled low mid-pass -> immediate head_ptr=0, mid_ptr=16 (MID_PTR_OFFSET=16), busy_o 0.
REQ-042 The bench SHALL cover: start_i asserted during RUN -> ignored, sequence unaltered, exactly one done_o.
